qq_issue: RTL
=============

QQ_ISSUE -- requirements
Module: qq_issue

Interface
REQ-001 The block SHALL have parameter W, default 8: key width, matching the queue data width.
REQ-002 The block SHALL have parameter CD, default 4: command buffer depth, a power of 2 and at least 2.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  in  1  upstream command valid.
REQ-006 cmd_op  in  1  command type: 0 = enqueue, 1 = dequeue.
REQ-007 cmd_data  in  W  enqueue key (ignored for dequeue).
REQ-008 cmd_ready  out  1  command buffer can accept; transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-009 enq_o  out  1  enqueue pulse to the queue.
REQ-010 deq_o  out  1  dequeue pulse to the queue.
REQ-011 data_o  out  W  key presented to the queue.
REQ-012 q_rdy  in  1  queue idle and able to take an operation.
REQ-013 q_full  in  1  queue full flag.
REQ-014 q_empty  in  1  queue empty flag.
REQ-015 q_dout  in  W  queue head (minimum) value.
REQ-016 rsp_valid  out  1  one-cycle response strobe; not back-pressured.
REQ-017 rsp_err  out  1  command rejected (qualified by rsp_valid).
REQ-018 rsp_data  out  W  dequeued key; 0 for enqueue responses and for any error response.
REQ-019 err_cnt  out  8  count of rejected commands (see Configuration).

Function
REQ-020 The command buffer SHALL be an in-order FIFO of CD entries of {op, data}; cmd_ready SHALL be 1 exactly when the buffer is not full.
REQ-021 When the buffer is full, cmd_ready SHALL be 0 even if a pop occurs in the same cycle; a push and a pop in the same cycle SHALL be legal when the buffer is not full.
REQ-022 Buffer pointers SHALL wrap modulo CD; the occupancy counter SHALL be $clog2(CD)+1 bits wide.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-024 IDLE SHALL move to ISSUE when the buffer is non-empty, q_rdy=1, and the head command is legal; an illegal head command SHALL move it to RESP with the error flag set.
REQ-025 Legality SHALL be sampled in IDLE: an enqueue is illegal when q_full=1; a dequeue is illegal when q_empty=1.
REQ-026 Illegal commands SHALL be popped and SHALL NOT produce enq_o or deq_o.
REQ-027 In ISSUE, enq_o or deq_o (per op) SHALL be high for exactly one cycle with data_o equal to the head data, the head SHALL be popped, and the FSM SHALL go to WAIT.
REQ-028 WAIT SHALL last at least one cycle and SHALL exit to RESP on the first cycle with q_rdy=1; for a dequeue, q_dout SHALL be captured on that cycle.
REQ-029 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE.
REQ-030 enq_o and deq_o SHALL never both be 1, and at most one operation SHALL be outstanding at the queue.
REQ-031 Latency: a command accepted at edge N into an empty buffer with the queue idle SHALL produce its pulse in cycle N+2 (IDLE in N+1, ISSUE in N+2).
REQ-032 data_o SHALL hold its last value outside ISSUE.

Reset
REQ-033 While rst=0, the block SHALL be in IDLE with the buffer empty and cmd_ready=1, enq_o=0, deq_o=0, data_o=0, rsp_valid=0, rsp_err=0, rsp_data=0, err_cnt=0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered and in-flight commands and SHALL produce no response for them.

Configuration
REQ-035 Macro QQ_ISSUE_ERRCNT_EN defined: err_cnt SHALL increment by 1 on each RESP with rsp_err=1 and saturate at 255.
REQ-036 Macro QQ_ISSUE_ERRCNT_EN undefined: err_cnt SHALL be constant 0, with no counter flops.

Verification
REQ-037 Reset, then enqueue 0x05 with q_rdy=1 and q_full=0 -> enq_o one cycle with data_o=0x05, then rsp_valid=1, rsp_err=0, rsp_data=0.
REQ-038 Dequeue with q_empty=0 and q_dout=0x03 when q_rdy returns -> deq_o one cycle, rsp_data=0x03, rsp_err=0.
REQ-039 Dequeue with q_empty=1 -> no deq_o, rsp_valid with rsp_err=1, rsp_data=0; err_cnt=1 with the macro defined, 0 without.
REQ-040 Hold q_rdy=0 and push 5 commands with CD=4 -> cmd_ready=0 after the 4th; then release q_rdy -> 4 responses in order, after which the 5th command is accepted.
REQ-041 q_rdy held low for 3 cycles after an enq pulse -> FSM stays in WAIT, no second pulse, response follows the cycle q_rdy returns high.
REQ-042 Assert rst during WAIT with 2 commands buffered -> all outputs at reset values, cmd_ready=1, and no responses are emitted after release.

Source files
------------

// File: rtl/qq_issue_if.sv
// qq_issue_if: command, queue-control and response signals of qq_issue.
// The slave modport is the issue block; master is its environment.
interface qq_issue_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_op;
    logic [W-1:0] cmd_data;
    logic         cmd_ready;
    logic         enq_o;
    logic         deq_o;
    logic [W-1:0] data_o;
    logic         q_rdy;
    logic         q_full;
    logic         q_empty;
    logic [W-1:0] q_dout;
    logic         rsp_valid;
    logic         rsp_err;
    logic [W-1:0] rsp_data;
    logic [7:0]   err_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, q_rdy, q_full, q_empty, q_dout,
        output cmd_ready, enq_o, deq_o, data_o, rsp_valid, rsp_err, rsp_data, err_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, q_rdy, q_full, q_empty, q_dout,
        input  cmd_ready, enq_o, deq_o, data_o, rsp_valid, rsp_err, rsp_data, err_cnt
    );
endinterface

// File: rtl/qq_issue.sv
// qq_issue: buffers enqueue/dequeue commands and issues them one at a time
// to a priority queue, returning one response per command.
// Optional feature: define QQ_ISSUE_ERRCNT_EN for a saturating count of
// rejected commands on err_cnt; without it err_cnt is tied to zero.
module qq_issue #(
    parameter int W  = 8,
    parameter int CD = 4
) (
    input logic       clk,
    input logic       rst,
    qq_issue_if.slave bus
);
    localparam int AW = $clog2(CD);

    localparam logic [AW:0]   FULL_CNT = CD[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [W:0]    buf_mem [CD];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_op;
    logic [W-1:0]  head_data;
    logic          head_legal;
    logic          start;
    logic [1:0]    state;
    logic          cur_op;

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign bus.cmd_ready = ~full;
    assign push          = bus.cmd_valid & ~full;

    assign {head_op, head_data} = buf_mem[rd_ptr];

    // A head command is judged against the queue flags while we sit in IDLE.
    assign head_legal = head_op ? ~bus.q_empty : ~bus.q_full;
    assign start      = (state == IDLE) & ~empty & bus.q_rdy;

    // Legal commands leave the buffer when issued, rejected ones straight from IDLE.
    assign pop = (state == ISSUE) | (start & ~head_legal);

    // Store accepted commands; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_data};
        end
    end

    // Buffer pointers wrap naturally because CD is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: pulses and the response strobe are registered on state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur_op        <= 1'b0;
            bus.enq_o     <= 1'b0;
            bus.deq_o     <= 1'b0;
            bus.data_o    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            bus.enq_o <= 1'b0;
            bus.deq_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (head_legal) begin
                            state      <= ISSUE;
                            cur_op     <= head_op;
                            bus.enq_o  <= ~head_op;
                            bus.deq_o  <= head_op;
                            bus.data_o <= head_data;
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.q_rdy) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_data  <= cur_op ? bus.q_dout : '0;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_data  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef QQ_ISSUE_ERRCNT_EN
    logic [7:0] err_count;

    // Count each rejected response once, holding at the top value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= 8'd0;
        end else if ((state == RESP) && bus.rsp_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.err_cnt = err_count;
`else
    assign bus.err_cnt = 8'd0;
`endif

endmodule
